// File: rtl/gray_codec_pkg.sv
// ============================================================================
// Module   : gray_codec_pkg
// Brief    : Shared constants, slice helpers and stage header record for the
//            pipelined Gray/binary codec.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package gray_codec_pkg;

    localparam logic MODE_G2B = 1'b0;
    localparam logic MODE_B2G = 1'b1;

    // Bits resolved per stage: ceil(n / stages).
    function automatic int chunk_of(input int n, input int stages);
        return (n + stages - 1) / stages;
    endfunction

    function automatic int slice_hi(input int n, input int chunk, input int idx);
        return n - 1 - idx * chunk;
    endfunction

    function automatic int slice_lo(input int n, input int chunk, input int idx);
        int lo;
        lo = n - (idx + 1) * chunk;
        return (lo < 0) ? 0 : lo;
    endfunction

    // Width-independent part of a stage record; raw/part are appended per N.
    typedef struct packed {
        logic valid;
        logic mode;
        logic err;
    } stage_hdr_t;

endpackage

`default_nettype wire

// File: rtl/gray_codec_stage.sv
// ============================================================================
// Module   : gray_codec_stage
// Brief    : One pipeline stage: resolves its slice of the gray->bin prefix
//            chain (stage 0 also does bin->gray) and registers the record.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module gray_codec_stage
    import gray_codec_pkg::*;
#(
    parameter int N     = 8,
    parameter int CHUNK = 4,
    parameter int IDX   = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_adv,
    input  logic         i_valid,
    input  logic         i_mode,
    input  logic         i_err,
    input  logic [N-1:0] i_raw,
    input  logic [N-1:0] i_part,
    output logic         o_valid,
    output logic         o_mode,
    output logic         o_err,
    output logic [N-1:0] o_raw,
    output logic [N-1:0] o_part
);

    localparam int c_hi = slice_hi(N, CHUNK, IDX);

    typedef struct packed {
        stage_hdr_t     hdr;
        logic [N-1:0]   raw;
        logic [N-1:0]   part;
    } stage_rec_t;

    stage_rec_t   r_rec;
    logic [N-1:0] w_part;

    generate
        if (c_hi < 0) begin : g_pass
            assign w_part = i_part;
        end else begin : g_slice
            localparam int c_lo = slice_lo(N, CHUNK, IDX);
            logic w_carry;

            // Prefix bit handed down from the stage above (none for the MSB).
            if (c_hi == N - 1) begin : g_top
                assign w_carry = 1'b0;
            end else begin : g_mid
                assign w_carry = i_part[c_hi+1];
            end

            always_comb begin
                logic c;
                c      = w_carry;
                w_part = i_part;
                if (i_mode == MODE_B2G) begin
                    if (IDX == 0) begin
                        w_part = i_raw ^ (i_raw >> 1);
                    end
                end else begin
                    for (int i = N - 1; i >= 0; i--) begin
                        if (i <= c_hi && i >= c_lo) begin
                            c         = c ^ i_raw[i];
                            w_part[i] = c;
                        end
                    end
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rec <= '0;
        end else if (i_adv) begin
            r_rec <= {i_valid, i_mode, i_err, i_raw, w_part};
        end
    end

    assign o_valid = r_rec.hdr.valid;
    assign o_mode  = r_rec.hdr.mode;
    assign o_err   = r_rec.hdr.err;
    assign o_raw   = r_rec.raw;
    assign o_part  = r_rec.part;

endmodule

`default_nettype wire

// File: rtl/gray_codec_pipe.sv
// ============================================================================
// Module   : gray_codec_pipe
// Brief    : Pipelined bidirectional Gray/binary converter with valid/ready
//            flow control. Define GRAY_CODEC_CHK_EN to add the out_err
//            Gray-adjacency checker.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module gray_codec_pipe
    import gray_codec_pkg::*;
#(
    parameter int N      = 8,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_mode,
    input  logic [N-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_mode,
    output logic [N-1:0] out_data
`ifdef GRAY_CODEC_CHK_EN
    ,
    output logic         out_err
`endif
);

    localparam int c_chunk = chunk_of(N, STAGES);

    logic                  w_adv;
    logic                  w_in_err;
    logic [STAGES:0]       w_valid;
    logic [STAGES:0]       w_mode;
    logic [STAGES:0]       w_err;
    logic [STAGES:0][N-1:0] w_raw;
    logic [STAGES:0][N-1:0] w_part;

    // Single global enable: the whole pipe moves only when the output slot frees.
    assign w_adv    = !out_valid || out_ready;
    assign in_ready = w_adv;

    assign w_valid[0] = in_valid;
    assign w_mode[0]  = in_mode;
    assign w_err[0]   = w_in_err;
    assign w_raw[0]   = in_data;
    assign w_part[0]  = '0;

    generate
        for (genvar k = 0; k < STAGES; k++) begin : g_stage
            gray_codec_stage #(
                .N     (N),
                .CHUNK (c_chunk),
                .IDX   (k)
            ) u_stage (
                .clk     (clk),
                .rst     (rst),
                .i_adv   (w_adv),
                .i_valid (w_valid[k]),
                .i_mode  (w_mode[k]),
                .i_err   (w_err[k]),
                .i_raw   (w_raw[k]),
                .i_part  (w_part[k]),
                .o_valid (w_valid[k+1]),
                .o_mode  (w_mode[k+1]),
                .o_err   (w_err[k+1]),
                .o_raw   (w_raw[k+1]),
                .o_part  (w_part[k+1])
            );
        end
    endgenerate

    assign out_valid = w_valid[STAGES];
    assign out_mode  = w_mode[STAGES];
    assign out_data  = w_part[STAGES];

`ifdef GRAY_CODEC_CHK_EN
    logic [N-1:0] r_prev;
    logic         r_have_prev;
    logic [N-1:0] w_diff;
    logic         w_take;
    logic         w_unused;

    assign w_take = in_valid && w_adv && (in_mode == MODE_G2B);
    assign w_diff = in_data ^ r_prev;
    // More than one differing bit <=> clearing the lowest set bit leaves a non-zero word.
    assign w_in_err = (in_mode == MODE_G2B) && r_have_prev &&
                      ((w_diff & (w_diff - N'(1))) != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prev      <= '0;
            r_have_prev <= 1'b0;
        end else if (w_take) begin
            r_prev      <= in_data;
            r_have_prev <= 1'b1;
        end
    end

    assign out_err  = w_err[STAGES];
    assign w_unused = ^w_raw[STAGES];
`else
    logic w_unused;

    assign w_in_err = 1'b0;
    assign w_unused = ^{w_raw[STAGES], w_err[STAGES]};
`endif

endmodule

`default_nettype wire

// File: tb/tb_gray_codec_pipe.sv
// ============================================================================
// Module   : tb_gray_codec_pipe
// Brief    : Scoreboard bench for gray_codec_pipe (N=8/STAGES=2 main DUT plus
//            N=4 instances with STAGES 1, 3 and 4).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gray_codec_pipe;

    localparam int N      = 8;
    localparam int STAGES = 2;

    typedef struct {
        logic [7:0] data;
        logic       mode;
        logic       err;
        int         acc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic       in_mode;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic       out_mode;
    logic [7:0] out_data;
    logic       out_err;

    logic       v4;
    logic       m4;
    logic [3:0] d4;

    int   checks = 0;
    int   errors = 0;
    int   adv_cnt = 0;
    exp_t q[$];

    // Reflected-binary tables: g_tbl[b] is the Gray code of b, g_inv its inverse.
    logic [7:0] g_tbl [256];
    logic [7:0] g_inv [256];
    logic [7:0] m_prev;
    logic       m_have;
    logic       rand_done;

    always #5 clk = ~clk;

    gray_codec_pipe #(.N(N), .STAGES(STAGES)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mode   (in_mode),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_mode  (out_mode),
        .out_data  (out_data)
`ifdef GRAY_CODEC_CHK_EN
        ,
        .out_err   (out_err)
`endif
    );

`ifndef GRAY_CODEC_CHK_EN
    assign out_err = 1'b0;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: required event did not occur as expected", name);
    endtask

    task automatic build_tables();
        g_tbl[0] = 8'h00;
        for (int k = 0; k < 8; k++) begin
            int size;
            size = 1 << k;
            for (int j = 0; j < size; j++)
                g_tbl[size + j] = g_tbl[size - 1 - j] | 8'(size);
        end
        for (int i = 0; i < 256; i++)
            g_inv[g_tbl[i]] = 8'(i);
    endtask

    task automatic send(input logic m, input logic [7:0] d);
        exp_t e;
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_mode  = m;
        in_data  = d;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (in_ready) begin
                e.data = m ? g_tbl[d] : g_inv[d];
                e.mode = m;
                e.err  = 1'b0;
`ifdef GRAY_CODEC_CHK_EN
                if (!m) begin
                    if (m_have && ($countones(d ^ m_prev) > 1))
                        e.err = 1'b1;
                    m_prev = d;
                    m_have = 1'b1;
                end
`endif
                e.acc = adv_cnt;
                q.push_back(e);
                return;
            end
        end
        fail("accept_timeout");
    endtask

    task automatic idle(input int n);
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (n - 1) @(posedge clk);
    endtask

    task automatic drain();
        for (int t = 0; t < 300 && q.size() != 0; t++)
            @(posedge clk);
        if (q.size() != 0)
            fail("drain_timeout");
    endtask

    // Main monitor: compares every presented word against the scoreboard head.
    always @(negedge clk) begin
        if (!rst) begin
            check("in_ready", 32'(in_ready), 32'(!out_valid || out_ready));
            if (out_valid) begin
                if (q.size() == 0) begin
                    fail("unexpected_output");
                end else begin
                    check("out_data", 32'(out_data), 32'(q[0].data));
                    check("out_mode", 32'(out_mode), 32'(q[0].mode));
                    check("out_err",  32'(out_err),  32'(q[0].err));
                    if (out_ready) begin
                        check("latency", 32'(adv_cnt - q[0].acc), 32'(STAGES));
                        void'(q.pop_front());
                    end
                end
            end
        end
        if (!out_valid || out_ready)
            adv_cnt <= adv_cnt + 1;
    end

    generate
        for (genvar j = 0; j < 3; j++) begin : g_n4
            localparam int ST = (j == 0) ? 1 : ((j == 1) ? 3 : 4);
            logic       ir;
            logic       ov;
            logic       om;
            logic [3:0] od;
            logic       oe;
            logic [4:0] q4[$];
            logic [7:0] idx;

            gray_codec_pipe #(.N(4), .STAGES(ST)) u_dut (
                .clk       (clk),
                .rst       (rst),
                .in_valid  (v4),
                .in_ready  (ir),
                .in_mode   (m4),
                .in_data   (d4),
                .out_valid (ov),
                .out_ready (1'b1),
                .out_mode  (om),
                .out_data  (od)
`ifdef GRAY_CODEC_CHK_EN
                ,
                .out_err   (oe)
`endif
            );

`ifndef GRAY_CODEC_CHK_EN
            assign oe = 1'b0;
`endif

            always @(negedge clk) begin
                if (!rst) begin
                    if (ov) begin
                        if (q4.size() == 0)
                            fail($sformatf("n4_s%0d_unexpected", ST));
                        else
                            check($sformatf("n4_s%0d_word", ST), 32'({om, od}), 32'(q4.pop_front()));
                    end
                    if (v4 && ir) begin
                        idx = {4'h0, d4};
                        q4.push_back({m4, m4 ? g_tbl[idx][3:0] : g_inv[idx][3:0]});
                    end
                end
            end
        end
    endgenerate

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        build_tables();
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_mode   = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b1;
        v4        = 1'b0;
        m4        = 1'b0;
        d4        = 4'h0;
        m_prev    = 8'h00;
        m_have    = 1'b0;
        rand_done = 1'b0;

        repeat (2) @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data",  32'(out_data),  32'd0);
        check("rst_out_mode",  32'(out_mode),  32'd0);
        check("rst_out_err",   32'(out_err),   32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        @(posedge clk); #1;
        rst = 1'b0;

        // Single gray->bin word, then back-to-back bin->gray pair.
        send(1'b0, 8'hC3);
        idle(4);
        send(1'b1, 8'h82);
        send(1'b1, 8'hFF);
        idle(4);
        drain();

        // Ascending stream with a 5-cycle downstream stall in the middle.
        fork
            begin
                for (int i = 0; i < 16; i++)
                    send(1'b0, 8'(i));
                idle(1);
            end
            begin
                repeat (6) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (5) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();

        // Random words, modes, gaps and backpressure.
        fork
            begin
                for (int i = 0; i < 150; i++) begin
                    if ($urandom_range(0, 3) == 0)
                        idle(1);
                    send(1'(($urandom_range(0, 1))), 8'($urandom));
                end
                idle(1);
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk); #1;
                    out_ready = ($urandom_range(0, 9) < 7);
                end
                out_ready = 1'b1;
            end
        join
        drain();

        // Reset with two words in flight.
        send(1'b0, 8'h11);
        send(1'b0, 8'h22);
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst      = 1'b1;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_out_data",  32'(out_data),  32'd0);
        q.delete();
        m_have = 1'b0;
        m_prev = 8'h00;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (6) @(posedge clk);

`ifdef GRAY_CODEC_CHK_EN
        // Adjacency sequence with an interleaved bin->gray word.
        send(1'b0, 8'h00);
        send(1'b0, 8'h01);
        send(1'b1, 8'h55);
        send(1'b0, 8'h03);
        send(1'b0, 8'h00);
`else
        send(1'b0, 8'h3C);
`endif
        idle(4);
        drain();

        // N=4 instances: every input in both modes plus a round trip.
        for (int x = 0; x < 16; x++) begin
            logic [7:0] gx;
            gx = g_tbl[x];
            @(posedge clk); #1;
            v4 = 1'b1; m4 = 1'b1; d4 = 4'(x);
            @(posedge clk); #1;
            m4 = 1'b0; d4 = gx[3:0];
            @(posedge clk); #1;
            m4 = 1'b0; d4 = 4'(x);
        end
        @(posedge clk); #1;
        v4 = 1'b0;
        repeat (8) @(posedge clk);
        check("n4_s1_drain", 32'(g_n4[0].q4.size()), 32'd0);
        check("n4_s3_drain", 32'(g_n4[1].q4.size()), 32'd0);
        check("n4_s4_drain", 32'(g_n4[2].q4.size()), 32'd0);

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/gray_codec_pipe.md
Name: gray_codec_pipe

Overview:
- Parametrised, pipelined, bidirectional Gray/binary converter. Successor to the team's combinational Gray-to-binary decoder.
- Per-transaction mode selects gray->bin or bin->gray.
- The gray->bin XOR prefix chain is split across STAGES register stages, so wide words close timing.
- Valid/ready streaming interface with full backpressure. Sits between asynchronous-FIFO pointer logic or encoder front-ends and binary datapaths.

Parameters:
- N, 8, data width in bits; legal range ≥ 2.
- STAGES, 2, pipeline register stages; legal range 1..N. Latency equals STAGES cycles.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  input word valid.
- in_ready  output  1  block can accept a word this cycle.
- in_mode  input  1  0 = gray->bin, 1 = bin->gray; sampled with the data.
- in_data  input  N  word to convert.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- out_mode  output  1  mode carried with the result.
- out_data  output  N  converted word.
- out_err  output  1  adjacency error; only present with GRAY_CODEC_CHK_EN.

Behaviour:
- Reset (asynchronous, active-high): all stage valid bits, out_valid, out_data, out_mode and out_err go to 0. in_ready is 1 during and after reset.
- Handshake:
  - Input transfer when in_valid & in_ready.
  - Output transfer when out_valid & out_ready.
  - out_data, out_mode and out_err are held stable while out_valid & !out_ready.
- Stall rule: one global advance, adv = !out_valid | out_ready.
  - in_ready = adv (combinational from out_ready and out_valid).
  - When adv=0 every stage holds.
  - When adv=1 all stages shift; a stage with valid=0 is a bubble. Bubbles are not collapsed.
- Latency: an accepted word appears on out_valid exactly STAGES adv-cycles later. Throughput is 1 word/cycle with out_ready held high.
- Work split: CHUNK = ceil(N/STAGES). Stage k (k=0..STAGES-1) resolves result bits [N-1-k*CHUNK] down to max(0, N-(k+1)*CHUNK), clamped to valid bit indices.
  - gray->bin: bin[N-1] = g[N-1]; bin[i] = bin[i+1] ^ g[i]. The carried prefix bit passes between stages inside the partial result register.
  - bin->gray: g[i] = b[i] ^ b[i+1], with g[N-1] = b[N-1]. Computed in stage 0; later stages pass it through.
  - Each stage registers {valid, mode, raw input word, partial result}.
- Stages beyond the last resolved bit (when STAGES > ceil(N/CHUNK)) pass through unchanged.
- Simultaneous out-accept and in-accept in the same cycle: both occur; there is no bubble insertion.
- Reset asserted mid-stream: in-flight words are discarded and no partial output is produced. After reset deassertion the first accepted word takes the full STAGES latency.
- in_data, in_mode and in_valid are don't-care while in_valid=0 or in_ready=0.

Optional Feature:
- Macro: GRAY_CODEC_CHK_EN.
- When defined:
  - The block keeps the last accepted gray->bin input word plus a "have_prev" flag; have_prev is reset to 0.
  - On each accepted word with in_mode=0 and have_prev=1, err = (popcount(in_data ^ prev) > 1).
  - err travels with the word and appears on out_err aligned with out_valid.
  - prev and have_prev update only on accepted mode-0 words. Mode-1 words carry err=0 and do not disturb prev.
- When undefined: out_err port is absent, and no prev register or popcount logic is built.

Decomposition:
- Package gray_codec_pkg holds:
  - localparam function for CHUNK, i.e. ceil-divide.
  - Mode encodings MODE_G2B=0 and MODE_B2G=1.
  - Stage record typedef {valid, mode, err, raw[N-1:0], part[N-1:0]}, parametrised via the function.
- Natural sub-module: gray_codec_stage. It takes one stage index parameter plus N and CHUNK, performs the partial XOR for its bit slice, and owns its pipeline register with the adv enable.
- Top-level responsibilities: generate loop instantiating gray_codec_stage, the adv/ready logic, and the optional checker.

Test Plan:
1. N=8, STAGES=2, out_ready=1; send mode0 8'hC3 -> out_data=8'h82, out_mode=0, exactly 2 cycles after accept.
2. Same config; send mode1 8'h82 then mode1 8'hFF back-to-back -> outputs 8'hC3 then 8'h80 on consecutive cycles.
3. Backpressure: stream mode0 8'h00..8'h0F; hold out_ready=0 for 5 cycles mid-stream.
   - in_ready=0 during the stall; out_data held.
   - All 16 results arrive in order with none lost or duplicated; 8'h0F -> 8'h0A.
4. Reset mid-stream: assert rst with 2 words in flight -> out_valid=0 immediately; after release, no stale words emerge.
5. Exhaustive for N=4 with STAGES=1, 3 and 4: all 16 inputs in both modes; gray->bin(bin->gray(x)) == x on round-trip.
6. GRAY_CODEC_CHK_EN: mode0 sequence 8'h00, 8'h01, 8'h03, 8'h00 -> out_err 0, 0, 0, 1. An interleaved mode1 word gives err=0 and does not break the sequence check.
